pipelined_csel_adder: RTL and testbench

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

---
 rtl/csel_pkg.sv | 16 +
 rtl/csel_block.sv | 20 ++
 rtl/pipelined_csel_adder.sv | 137 +++++++++++++
 tb/tb_pipelined_csel_adder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared types for the pipelined carry-select adder: operation encoding and
// the elaboration-time parameter legality check.
package csel_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   function automatic bit params_legal(int width, int block, int blocks_per_stage);
      if (width <= 0 || block <= 0 || blocks_per_stage <= 0) return 1'b0;
      if ((width % block) != 0) return 1'b0;
      return ((width / block) % blocks_per_stage) == 0;
   endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: both carry-0 and carry-1 sums are formed up front,
// the real carry-in only drives the final 2:1 select.
module csel_block #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout
);

   logic [BLOCK:0] sum0;
   logic [BLOCK:0] sum1;

   assign sum0 = {1'b0, a} + {1'b0, b};
   assign sum1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
   assign {cout, sum} = cin ? sum1 : sum0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control; each
// stage resolves BLOCKS_PER_STAGE blocks and forwards the still-unused operand bits.
module pipelined_csel_adder
   import csel_pkg::*;
#(
   parameter int WIDTH            = 32,
   parameter int BLOCK            = 8,
   parameter int BLOCKS_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   if (!params_legal(WIDTH, BLOCK, BLOCKS_PER_STAGE)) begin : g_bad_params
      $fatal(1, "pipelined_csel_adder: illegal WIDTH/BLOCK/BLOCKS_PER_STAGE combination");
   end

   localparam int NUM_BLOCKS = WIDTH / BLOCK;
   localparam int STAGES     = NUM_BLOCKS / BLOCKS_PER_STAGE;
   localparam int SW         = BLOCK * BLOCKS_PER_STAGE;

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Whole pipeline moves together; only a held result can stall it.
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;
   assign b_eff    = (op_t'(op) == OP_SUB) ? ~b : b;
   assign c0       = (op_t'(op) == OP_SUB) ? 1'b1 : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IN_W  = WIDTH - k * SW;
      localparam int RES_W = (k + 1) * SW;

      logic             vin;
      logic [IN_W-1:0]  ain;
      logic [IN_W-1:0]  bin;
      logic             c_in;
      logic [SW-1:0]    res;
      logic [RES_W-1:0] nxt_sum;
      logic             c_nxt;
      logic             v;
      logic             c;
      logic [RES_W-1:0] s;

      if (k == 0) begin : g_src
         assign vin     = in_valid;
         assign ain     = a;
         assign bin     = b_eff;
         assign c_in    = c0;
         assign nxt_sum = res;
      end else begin : g_src
         assign vin     = g_stage[k-1].v;
         assign ain     = g_stage[k-1].g_fwd.a_q;
         assign bin     = g_stage[k-1].g_fwd.b_q;
         assign c_in    = g_stage[k-1].c;
         assign nxt_sum = {res, g_stage[k-1].s};
      end

      for (genvar i = 0; i < BLOCKS_PER_STAGE; i++) begin : g_blk
         logic             blk_cin;
         logic             blk_cout;
         logic [BLOCK-1:0] blk_sum;

         if (i == 0) begin : g_cin
            assign blk_cin = c_in;
         end else begin : g_cin
            assign blk_cin = g_blk[i-1].blk_cout;
         end

         csel_block #(.BLOCK(BLOCK)) u_blk (
            .a    (ain[i*BLOCK +: BLOCK]),
            .b    (bin[i*BLOCK +: BLOCK]),
            .cin  (blk_cin),
            .sum  (blk_sum),
            .cout (blk_cout)
         );

         assign res[i*BLOCK +: BLOCK] = blk_sum;
      end

      assign c_nxt = g_blk[BLOCKS_PER_STAGE-1].blk_cout;

      // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values of its neighbours.
      always_ff @(posedge clk) begin
         if (!rst_n) v <= 1'b0;
         else if (advance) v <= vin;
      end

      if (k == STAGES - 1) begin : g_out
         logic ovf_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s     <= '0;
               c     <= 1'b0;
               ovf_q <= 1'b0;
            end else if (advance && vin) begin
               s     <= nxt_sum;
               c     <= c_nxt;
               ovf_q <= (ain[IN_W-1] == bin[IN_W-1]) && (res[SW-1] != ain[IN_W-1]);
            end
         end
      end else begin : g_fwd
         logic [IN_W-SW-1:0] a_q;
         logic [IN_W-SW-1:0] b_q;

         // NOTE: inner datapath registers carry no reset; their valid bit alone decides whether they mean anything.
         always_ff @(posedge clk) begin
            if (advance && vin) begin
               s   <= nxt_sum;
               c   <= c_nxt;
               a_q <= ain[IN_W-1:SW];
               b_q <= bin[IN_W-1:SW];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v;
   assign sum       = g_stage[STAGES-1].s;
   assign cout      = g_stage[STAGES-1].c;
   assign ovf       = g_stage[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: default 32/8/2 and 64/4/4 instances, a
// scoreboard per instance fed at acceptance and drained at delivery.
module tb_pipelined_csel_adder;
   import csel_pkg::*;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      longint      cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  in_valid = 2'b00;
   logic [1:0]  out_ready = 2'b11;
   logic [1:0]  cin = 2'b00;
   logic [1:0]  op = 2'b00;
   logic [31:0] a0 = '0, b0 = '0;
   logic [63:0] a1 = '0, b1 = '0;
   logic        rdy0, rdy1, ov0, ov1, co0, co1, of0, of1;
   logic [31:0] sum0;
   logic [63:0] sum1;

   exp_t   q0[$];
   exp_t   q1[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_csel_adder dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy0),
      .a(a0), .b(b0), .cin(cin[0]), .op(op[0]),
      .out_valid(ov0), .out_ready(out_ready[0]), .sum(sum0), .cout(co0), .ovf(of0)
   );

   pipelined_csel_adder #(.WIDTH(64), .BLOCK(4), .BLOCKS_PER_STAGE(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy1),
      .a(a1), .b(b1), .cin(cin[1]), .op(op[1]),
      .out_valid(ov1), .out_ready(out_ready[1]), .sum(sum1), .cout(co1), .ovf(of1)
   );

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int stg(int s);
      return (s != 0) ? 4 : 2;
   endfunction

   function automatic exp_t model(int s, logic [63:0] av, logic [63:0] bv, logic c, logic o);
      int          w;
      logic [63:0] mask, ae, be;
      logic [64:0] full;
      exp_t        e;
      w      = (s != 0) ? 64 : 32;
      mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      ae     = av & mask;
      be     = (o ? ~bv : bv) & mask;
      full   = {1'b0, ae} + {1'b0, be} + {64'd0, (o ? 1'b1 : c)};
      e.sum  = full[63:0] & mask;
      e.cout = full[w];
      e.ovf  = (ae[w-1] == be[w-1]) && (e.sum[w-1] != ae[w-1]);
      e.cyc  = -1;
      return e;
   endfunction

   function automatic logic ready(int s);
      return (s != 0) ? rdy1 : rdy0;
   endfunction

   function automatic logic ovalid(int s);
      return (s != 0) ? ov1 : ov0;
   endfunction

   function automatic logic [63:0] osum(int s);
      return (s != 0) ? sum1 : {32'd0, sum0};
   endfunction

   function automatic int qsize(int s);
      return (s != 0) ? q1.size() : q0.size();
   endfunction

   function automatic logic [63:0] front_sum(int s);
      if (qsize(s) == 0) return '1;
      return (s != 0) ? q1[0].sum : q0[0].sum;
   endfunction

   task automatic set_in(int s, logic [63:0] av, logic [63:0] bv, logic c, logic o);
      if (s == 0) begin
         a0 = av[31:0];
         b0 = bv[31:0];
      end else begin
         a1 = av;
         b1 = bv;
      end
      cin[s]      = c;
      op[s]       = o;
      in_valid[s] = 1'b1;
   endtask

   // Offers one beat; the expectation is queued at the negedge preceding the accepting edge.
   task automatic send(int s, logic [63:0] av, logic [63:0] bv, logic c, logic o, bit lat);
      exp_t e;
      bit   acc;
      acc = 1'b0;
      e   = model(s, av, bv, c, o);
      set_in(s, av, bv, c, o);
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         if (ready(s)) begin
            e.cyc = lat ? cyc + longint'(stg(s)) : -1;
            if (s != 0) q1.push_back(e);
            else q0.push_back(e);
            acc = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid[s] = 1'b0;
      check("accept", 64'(acc), 64'd1);
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(int s);
      for (int n = 0; n < 200 && qsize(s) != 0; n++) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", 64'(qsize(s)), 64'd0);
   endtask

   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst_n && ov0 && out_ready[0]) begin
         if (q0.size() == 0) check("unexpected_out32", 64'(ov0), 64'd0);
         else begin
            e = q0.pop_front();
            check("sum32", {32'd0, sum0}, e.sum);
            check("cout32", 64'(co0), 64'(e.cout));
            check("ovf32", 64'(of0), 64'(e.ovf));
            if (e.cyc >= 0) check("latency32", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst_n && ov1 && out_ready[1]) begin
         if (q1.size() == 0) check("unexpected_out64", 64'(ov1), 64'd0);
         else begin
            e = q1.pop_front();
            check("sum64", sum1, e.sum);
            check("cout64", 64'(co1), 64'(e.cout));
            check("ovf64", 64'(of1), 64'(e.ovf));
            if (e.cyc >= 0) check("latency64", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] m, av, bv;
      longint      t0;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid32", 64'(ov0), 64'd0);
      check("rst_sum32", {32'd0, sum0}, 64'd0);
      check("rst_cout32", 64'(co0), 64'd0);
      check("rst_ovf32", 64'(of0), 64'd0);
      check("rst_out_valid64", 64'(ov1), 64'd0);
      check("rst_sum64", sum1, 64'd0);
      check("rst_cout64", 64'(co1), 64'd0);
      check("rst_ovf64", 64'(of1), 64'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("in_ready_after_reset32", 64'(rdy0), 64'd1);
      check("in_ready_after_reset64", 64'(rdy1), 64'd1);
      @(posedge clk);
      #1;

      for (int s = 0; s < 2; s++) begin
         m = (s != 0) ? '1 : 64'h0000_0000_FFFF_FFFF;

         // Directed corners: full carry ripple, signed overflow, borrow, cin ignored on subtract.
         send(s, m, 64'd1, 1'b0, OP_ADD, 1'b1);
         drain(s);
         send(s, m >> 1, 64'd1, 1'b0, OP_ADD, 1'b1);
         send(s, 64'd5, 64'd7, 1'b0, OP_SUB, 1'b1);
         send(s, 64'd5, 64'd7, 1'b1, OP_SUB, 1'b1);
         send(s, 64'h1234_5678_9ABC_DEF0 & m, 64'h0FED_CBA9_8765_4321 & m, 1'b1, OP_ADD, 1'b1);
         send(s, (m >> 1) + 64'd1, 64'd1, 1'b0, OP_SUB, 1'b1);
         send(s, m, m, 1'b1, OP_ADD, 1'b1);
         drain(s);

         t0 = cyc;
         for (int i = 0; i < 100; i++)
            send(s, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'b1);
         check("throughput", 64'(cyc - t0), 64'd100);
         drain(s);

         send(s, 64'd100, 64'd23, 1'b0, OP_ADD, 1'b1);
         idle(1);
         send(s, 64'd3, 64'd9, 1'b0, OP_SUB, 1'b1);
         idle(2);
         send(s, m, 64'd0, 1'b1, OP_ADD, 1'b1);
         drain(s);

         for (int i = 0; i < stg(s) + 1; i++)
            send(s, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, OP_ADD, 1'b0);
         av = {$urandom, $urandom};
         bv = {$urandom, $urandom};
         out_ready[s] = 1'b0;
         set_in(s, av, bv, 1'b0, OP_SUB);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(ready(s)), 64'd0);
            check("stall_out_valid", 64'(ovalid(s)), 64'd1);
            check("stall_sum", osum(s), front_sum(s));
            @(posedge clk);
            #1;
         end
         out_ready[s] = 1'b1;
         send(s, av, bv, 1'b0, OP_SUB, 1'b0);
         drain(s);

         send(s, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, OP_ADD, 1'b0);
         send(s, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, OP_ADD, 1'b0);
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         if (s != 0) q1.delete();
         else q0.delete();
         @(negedge clk);
         check("post_reset_out_valid", 64'(ovalid(s)), 64'd0);
         check("post_reset_sum", osum(s), 64'd0);
         check("post_reset_in_ready", 64'(ready(s)), 64'd1);
         idle(8);
         send(s, 64'd40, 64'd2, 1'b0, OP_ADD, 1'b1);
         drain(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
